snd_pdm_dec: RTL and testbench

SND_PDM_DEC -- requirements
Module: snd_pdm_dec

---
 rtl/snd_pkg.sv | 14 +
 rtl/snd_sync2.sv | 23 ++
 rtl/snd_pdm_dec.sv | 114 +++++++++++
 tb/tb_snd_pdm_dec.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared definitions for the PDM/density-stream decoder: the decoder state
// encoding and the default decimation window length.
package snd_pkg;

    // Default window length in clk cycles per output sample.
    localparam int SND_DECIM_DEFAULT = 256;

    // Decoder state: IDLE while en is low, RUN while en is high.
    typedef enum logic {
        SND_IDLE = 1'b0,
        SND_RUN  = 1'b1
    } snd_state_e;

endpackage : snd_pkg

// File: rtl/snd_sync2.sv
// Two-flop synchroniser for the raw 1-bit audio stream. Both flops clear to 0
// on asynchronous reset so the first bits after reset read as zero.
module snd_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : snd_sync2

// File: rtl/snd_pdm_dec.sv
// Decimating decoder for a 1-bit density-modulated audio stream. Counts the
// ones in each window of DECIM clk cycles and offers the count on a
// valid/ready output with a one-entry buffer and a sticky overrun flag.
//
// Build option: define SND_PDM_DEC_SYNC_EN to pass snd through a 2-flop
// synchroniser (snd_sync2) before accumulation (+2 cycles latency). Without
// it, snd is taken to be synchronous to clk and accumulated directly.
//
// Handshake: a transfer happens on every rising edge where sample_valid and
// sample_ready are both high. sample is held stable while sample_valid is high
// and no transfer has occurred; sample_valid drops after a transfer unless a
// fresh window result loads on that same edge.
module snd_pdm_dec
    import snd_pkg::*;
#(
    parameter int DECIM    = SND_DECIM_DEFAULT,
    parameter int OUT_BITS = $clog2(DECIM + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                snd,
    output logic [OUT_BITS-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                clr_ovr,
    output snd_state_e          state
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0]    wcnt;
    logic [OUT_BITS-1:0] acc;
    logic                bit_in;
    logic [OUT_BITS-1:0] candidate;
    logic                win_done;
    logic                xfer;

`ifdef SND_PDM_DEC_SYNC_EN
    snd_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (snd),
        .q     (bit_in)
    );
`else
    assign bit_in = snd;
`endif

    // The edge that first samples en high is already a RUN edge: it counts the
    // first window bit, so a window is exactly DECIM edges with en high.
    // acc never exceeds DECIM-1 before the final add, so candidate fits.
    always_comb begin
        candidate = acc + OUT_BITS'(bit_in);
        win_done  = en && (wcnt == WCNT_LAST);
        xfer      = sample_valid && sample_ready;
    end

    // State register: follows en, visible on the state output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SND_IDLE;
        end else begin
            case (state)
                SND_IDLE: if (en)  state <= SND_RUN;
                SND_RUN:  if (!en) state <= SND_IDLE;
                default:           state <= SND_IDLE;
            endcase
        end
    end

    // Window counter and ones accumulator; both held at zero while idle and
    // restarted on the window-complete edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            acc  <= '0;
        end else if (!en || win_done) begin
            wcnt <= '0;
            acc  <= '0;
        end else begin
            wcnt <= wcnt + CNT_W'(1);
            acc  <= candidate;
        end
    end

    // One-entry output buffer: load a finished window if the buffer is empty
    // or draining this edge, otherwise drop it and flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else if (win_done && (!sample_valid || xfer)) begin
            sample       <= candidate;
            sample_valid <= 1'b1;
        end else if (xfer) begin
            sample_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (win_done && sample_valid && !xfer) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule : snd_pdm_dec

// File: tb/tb_snd_pdm_dec.sv
// Directed bench for snd_pdm_dec with DECIM=16. Inputs change and outputs are
// checked 1ns after each rising edge.
module tb_snd_pdm_dec;
    import snd_pkg::*;

    localparam int DECIM = 16;
    localparam int OB    = 5;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          snd;
    logic [OB-1:0] sample;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;
    logic          clr_ovr;
    snd_state_e    state;

    int errors = 0;
    int checks = 0;

    snd_pdm_dec #(.DECIM(DECIM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .snd          (snd),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .clr_ovr      (clr_ovr),
        .state        (state)
    );

    // clock: 10ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int s, input int v, input int o);
        check({tag, ".sample"}, int'(sample), s);
        check({tag, ".valid"}, int'(sample_valid), v);
        check({tag, ".overrun"}, int'(overrun), o);
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = 1'b0;
        snd          = 1'b0;
        sample_ready = 1'b0;
        clr_ovr      = 1'b0;
        #1;
        check_out("reset", 0, 0, 0);
        check("reset.state", int'(state), int'(SND_IDLE));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_out("post_reset_idle", 0, 0, 0);

`ifdef SND_PDM_DEC_SYNC_EN
        // snd steps 0->1 together with the first RUN edge; two bits are lost
        // in the synchroniser, so the first window counts 14.
        en = 1'b1; snd = 1'b1; sample_ready = 1'b1;
        repeat (15) tick();
        check("sync.w1_early", int'(sample_valid), 0);
        tick();
        check_out("sync.w1", 14, 1, 0);
        repeat (16) tick();
        check_out("sync.w2", 16, 1, 0);
`else
        // constant ones: first window completes on the 16th RUN edge
        en = 1'b1; snd = 1'b1; sample_ready = 1'b1;
        tick();
        check("run.state", int'(state), int'(SND_RUN));
        repeat (14) tick();
        check("ones.w1_early", int'(sample_valid), 0);
        tick();
        check_out("ones.w1", 16, 1, 0);
        tick();
        check("ones.drain", int'(sample_valid), 0);
        repeat (15) tick();
        check_out("ones.w2", 16, 1, 0);

        // constant zeros
        snd = 1'b0;
        repeat (16) tick();
        check_out("zeros", 0, 1, 0);

        // alternating 1,0
        for (int i = 0; i < 16; i++) begin
            snd = (i % 2 == 0);
            tick();
        end
        check_out("alt", 8, 1, 0);

        // consume, then stall across two windows: 16 kept, second dropped
        snd = 1'b1;
        tick();
        check("stall.drain", int'(sample_valid), 0);
        sample_ready = 1'b0;
        repeat (15) tick();
        check_out("stall.w1", 16, 1, 0);
        snd = 1'b0;
        repeat (16) tick();
        check_out("stall.w2", 16, 1, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check_out("clr_ovr", 16, 1, 0);

        // window now holds one zero bit; 15 ones follow, ready only on the
        // completion edge: new value 15 loads, valid stays high
        snd = 1'b1;
        repeat (14) tick();
        check_out("pend.before", 16, 1, 0);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        check_out("ready_on_done", 15, 1, 0);

        // stall another window to set overrun, then reset at wcnt=7
        repeat (16) tick();
        check_out("ovr_again", 15, 1, 1);
        repeat (7) tick();
        check_out("pre_rst", 15, 1, 1);
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0);
        check("async_rst.state", int'(state), int'(SND_IDLE));
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        en = 1'b1; snd = 1'b1; sample_ready = 1'b1;
        repeat (15) tick();
        check("rst_full.early", int'(sample_valid), 0);
        tick();
        check_out("rst_full", 16, 1, 0);

        // pause mid-window: counters clear, pending state otherwise kept
        repeat (5) tick();
        en = 1'b0;
        tick();
        check("pause.state", int'(state), int'(SND_IDLE));
        repeat (3) tick();
        check_out("pause.hold", 16, 0, 0);
        en = 1'b1; snd = 1'b0;
        repeat (15) tick();
        check("resume.early", int'(sample_valid), 0);
        tick();
        check_out("resume", 0, 1, 0);

        // idle retains a pending sample
        sample_ready = 1'b0;
        en = 1'b0;
        repeat (20) tick();
        check_out("idle.retain", 0, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_snd_pdm_dec
